// File: rtl/mutex_req_ctrl_if.sv
// Command, status and r/g handshake bundle between a mutex client and its requester.
// The controller takes the slave view; the client/arbiter side takes the master view.
interface mutex_req_ctrl_if #(
   parameter int unsigned LEN_W = 8
);
   localparam int unsigned CNT_W = 16;

   logic             acq_valid;
   logic [LEN_W-1:0] acq_len;
   logic             acq_ready;
   logic             r;
   logic             g;
   logic             owned;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] grant_cnt;

   modport master (
      output acq_valid, acq_len, g,
      input  acq_ready, r, owned, done, timeout, grant_cnt
   );

   modport slave (
      input  acq_valid, acq_len, g,
      output acq_ready, r, owned, done, timeout, grant_cnt
   );
endinterface

// File: rtl/mutex_req_ctrl.sv
// Clocked requester for one port of an async two-way mutex: turns an acquire/length
// command into a four-phase r/g handshake, holds the grant for len cycles, and withdraws on timeout.
module mutex_req_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LEN_W       = 8,
   parameter int unsigned TO_W        = 10,
   parameter int unsigned TIMEOUT     = 1000
) (
   input logic             clk,
   input logic             rst,
   mutex_req_ctrl_if.slave bus
);
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam bit          TO_EN   = (TIMEOUT != 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_REL} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_g_sync;
   logic [LEN_W-1:0]       r_len;
   logic [LEN_W-1:0]       r_hold_cnt;
   logic [TO_W-1:0]        r_to_cnt;
   logic                   r_abort;
   logic                   r_req;
   logic                   r_owned;
   logic                   r_done;
   logic                   r_timeout;
   logic [CNT_W-1:0]       r_grant_cnt;
   logic                   w_g_s;
   logic                   w_accept;

   assign w_g_s         = r_g_sync[SYNC_STAGES-1];
   // New request only once the previous grant has returned to zero.
   assign bus.acq_ready = (r_state == S_IDLE) && !w_g_s && !rst;
   assign w_accept      = bus.acq_valid && bus.acq_ready;

   assign bus.r         = r_req;
   assign bus.owned     = r_owned;
   assign bus.done      = r_done;
   assign bus.timeout   = r_timeout;
   assign bus.grant_cnt = r_grant_cnt;

   always_ff @(posedge clk) begin
      if (rst) r_g_sync <= '0;
      else     r_g_sync <= {r_g_sync[SYNC_STAGES-2:0], bus.g};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_hold_cnt  <= '0;
         r_to_cnt    <= '0;
         r_abort     <= 1'b0;
         r_req       <= 1'b0;
         r_owned     <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_grant_cnt <= '0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_len    <= (bus.acq_len == '0) ? LEN_W'(1) : bus.acq_len;
                  r_req    <= 1'b1;
                  r_to_cnt <= '0;
                  r_state  <= S_REQ;
               end
            end
            // A grant seen in the expiry cycle takes priority over the timeout.
            S_REQ: begin
               if (w_g_s) begin
                  r_hold_cnt  <= r_len;
                  r_owned     <= 1'b1;
                  r_grant_cnt <= r_grant_cnt + CNT_W'(1);
                  r_state     <= S_HOLD;
               end else if (TO_EN && (r_to_cnt == TO_W'(TO_LAST))) begin
                  r_req   <= 1'b0;
                  r_abort <= 1'b1;
                  r_state <= S_REL;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == LEN_W'(1)) begin
                  r_owned <= 1'b0;
                  r_req   <= 1'b0;
                  r_abort <= 1'b0;
                  r_state <= S_REL;
               end else begin
                  r_hold_cnt <= r_hold_cnt - LEN_W'(1);
               end
            end
            // Wait out any grant (including a late one) before reporting completion.
            S_REL: begin
               if (!w_g_s) begin
                  r_done    <= !r_abort;
                  r_timeout <= r_abort;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mutex_req_ctrl.sv
// Bench for mutex_req_ctrl: two instances share a behavioural mutex, a third (short timeout)
// has its grant driven directly; event timing is predicted from handshake arithmetic.
module tb_mutex_req_ctrl;
   localparam int unsigned LEN_W = 8;
   localparam int          TO_T  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mutex_req_ctrl_if #(.LEN_W(LEN_W)) bus_a ();
   mutex_req_ctrl_if #(.LEN_W(LEN_W)) bus_b ();
   mutex_req_ctrl_if #(.LEN_W(LEN_W)) bus_t ();

   mutex_req_ctrl #(.SYNC_STAGES(2), .LEN_W(LEN_W), .TO_W(10), .TIMEOUT(64))
      u_a (.clk(clk), .rst(rst), .bus(bus_a));
   mutex_req_ctrl #(.SYNC_STAGES(2), .LEN_W(LEN_W), .TO_W(10), .TIMEOUT(64))
      u_b (.clk(clk), .rst(rst), .bus(bus_b));
   mutex_req_ctrl #(.SYNC_STAGES(2), .LEN_W(LEN_W), .TO_W(10), .TIMEOUT(TO_T))
      u_t (.clk(clk), .rst(rst), .bus(bus_t));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Reference bookkeeping
   int q_a[$];
   int q_b[$];
   int acc_a, acc_b, done_a, done_b, tmo_a, tmo_b, run_a, run_b;
   int viol = 0;
   int own  = 0;
   logic prev_a, prev_b;

   // Monitor first, then the behavioural mutex updates its grants mid-cycle.
   always @(negedge clk) begin
      int e;
      if (rst) begin
         q_a.delete(); q_b.delete();
         acc_a = 0; acc_b = 0; done_a = 0; done_b = 0; tmo_a = 0; tmo_b = 0;
         run_a = 0; run_b = 0; prev_a = 1'b0; prev_b = 1'b0;
      end else begin
         if (bus_a.owned && bus_b.owned) viol++;
         if (bus_a.owned && !bus_a.r) viol++;
         if (bus_b.owned && !bus_b.r) viol++;
         if (bus_t.owned && !bus_t.r) viol++;
         if (bus_a.done && bus_a.timeout) viol++;
         if (bus_b.done && bus_b.timeout) viol++;
         if (bus_t.done && bus_t.timeout) viol++;
         if (bus_a.done) done_a++;
         if (bus_b.done) done_b++;
         if (bus_a.timeout) tmo_a++;
         if (bus_b.timeout) tmo_b++;
         if (bus_a.owned) run_a++;
         else if (prev_a) begin
            e = (q_a.size() > 0) ? q_a.pop_front() : 0;
            chk("a_hold_len", run_a, e);
            run_a = 0;
         end
         if (bus_b.owned) run_b++;
         else if (prev_b) begin
            e = (q_b.size() > 0) ? q_b.pop_front() : 0;
            chk("b_hold_len", run_b, e);
            run_b = 0;
         end
         prev_a = bus_a.owned;
         prev_b = bus_b.owned;
      end
      if (own == 1 && !bus_a.r) own = 0;
      if (own == 2 && !bus_b.r) own = 0;
      if (own == 0) begin
         if (bus_a.r && bus_b.r) own = int'($urandom_range(1, 2));
         else if (bus_a.r)       own = 1;
         else if (bus_b.r)       own = 2;
      end
      bus_a.g = (own == 1);
      bus_b.g = (own == 2);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic acquire(input int which, input int len);
      logic rdy;
      bit   got = 1'b0;
      int   lm  = (len == 0) ? 1 : len;
      case (which)
         0: begin bus_a.acq_valid = 1'b1; bus_a.acq_len = LEN_W'(len); end
         1: begin bus_b.acq_valid = 1'b1; bus_b.acq_len = LEN_W'(len); end
         default: begin bus_t.acq_valid = 1'b1; bus_t.acq_len = LEN_W'(len); end
      endcase
      for (int i = 0; i < 300 && !got; i++) begin
         rdy = (which == 0) ? bus_a.acq_ready : (which == 1) ? bus_b.acq_ready : bus_t.acq_ready;
         if (rdy) begin
            @(posedge clk);
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) chk("acq_wait", 0, 1);
      #1;
      case (which)
         0: begin bus_a.acq_valid = 1'b0; if (got) begin q_a.push_back(lm); acc_a++; end end
         1: begin bus_b.acq_valid = 1'b0; if (got) begin q_b.push_back(lm); acc_b++; end end
         default: bus_t.acq_valid = 1'b0;
      endcase
   endtask

   function automatic logic [31:0] win(input int lo, input int hi);
      logic [31:0] m = '0;
      for (int k = 0; k < 32; k++) if (k >= lo && k < hi) m[k] = 1'b1;
      return m;
   endfunction

   // Trace 32 cycles from the accept edge (index 0). Grant rises in the cycle after edge
   // g_up and falls in the cycle after edge g_dn (g_dn<0: grant follows r). FSM sees
   // a grant change three edges later.
   task automatic run_trace(input int which, input int len, input int to,
                            input int g_up, input int g_dn, input string tag,
                            output bit granted);
      logic [31:0] t_r, t_o, t_d, t_t, t_y, e_r, e_o, e_d, e_t, e_y;
      int lm, gs, rf, dn, fin;
      lm      = (len == 0) ? 1 : len;
      gs      = (g_up >= 0) ? g_up + 3 : 1000;
      granted = (g_up >= 0) && (gs <= to);
      rf      = granted ? gs + lm : to;
      dn      = (g_dn < 0) ? rf : g_dn;
      fin     = (g_up >= 0 && g_up + 3 <= rf + 1 && rf + 1 <= dn + 2) ? dn + 3 : rf + 1;
      e_r = win(0, rf);
      e_o = granted ? win(gs, rf) : '0;
      e_d = granted ? win(fin, fin + 1) : '0;
      e_t = granted ? '0 : win(fin, fin + 1);
      e_y = win(fin, 32);
      acquire(which, len);
      for (int k = 0; k < 32; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (which == 0) begin
            t_r[k] = bus_a.r; t_o[k] = bus_a.owned; t_d[k] = bus_a.done;
            t_t[k] = bus_a.timeout; t_y[k] = bus_a.acq_ready;
         end else begin
            t_r[k] = bus_t.r; t_o[k] = bus_t.owned; t_d[k] = bus_t.done;
            t_t[k] = bus_t.timeout; t_y[k] = bus_t.acq_ready;
            if (k == g_up) bus_t.g = 1'b1;
            if (k == g_dn) bus_t.g = 1'b0;
         end
      end
      chk({tag, "_r"},     t_r, e_r);
      chk({tag, "_owned"}, t_o, e_o);
      chk({tag, "_done"},  t_d, e_d);
      chk({tag, "_tmo"},   t_t, e_t);
      chk({tag, "_ready"}, t_y, e_y);
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         ok = bus_a.acq_ready && bus_b.acq_ready && bus_t.acq_ready;
      end
      @(negedge clk);
      chk(tag, ok, 1);
   endtask

   task automatic rnd_client(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         acquire(which, int'($urandom_range(0, 20)));
      end
   endtask

   int gc_a = 0;
   int gc_t = 0;
   int lens[4] = '{3, 0, 1, 7};

   initial begin
      bit g;
      rst = 1'b1;
      bus_a.acq_valid = 1'b0; bus_a.acq_len = '0;
      bus_b.acq_valid = 1'b0; bus_b.acq_len = '0;
      bus_t.acq_valid = 1'b0; bus_t.acq_len = '0; bus_t.g = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_r",       {bus_a.r, bus_b.r, bus_t.r}, 0);
      chk("rst_owned",   {bus_a.owned, bus_b.owned, bus_t.owned}, 0);
      chk("rst_pulses",  {bus_a.done, bus_a.timeout, bus_t.done, bus_t.timeout}, 0);
      chk("rst_gcnt",    bus_a.grant_cnt | bus_t.grant_cnt, 0);
      chk("rst_ready",   {bus_a.acq_ready, bus_t.acq_ready}, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", {bus_a.acq_ready, bus_b.acq_ready, bus_t.acq_ready}, 3'b111);

      foreach (lens[i]) begin
         run_trace(0, lens[i], 64, 0, -1, $sformatf("a_len%0d", lens[i]), g);
         if (g) gc_a++;
         chk($sformatf("a_len%0d_gcnt", lens[i]), bus_a.grant_cnt, gc_a);
      end

      run_trace(2, 4, TO_T, -1, -1, "t_timeout", g);
      if (g) gc_t++;
      chk("t_timeout_gcnt", bus_t.grant_cnt, gc_t);
      run_trace(2, 4, TO_T, 6, 10, "t_late", g);
      if (g) gc_t++;
      chk("t_late_gcnt", bus_t.grant_cnt, gc_t);
      run_trace(2, 2, TO_T, 5, 10, "t_coincide", g);
      if (g) gc_t++;
      chk("t_coincide_gcnt", bus_t.grant_cnt, gc_t);

      // Reset during the second of five hold cycles
      acquire(0, 5);
      repeat (4) begin @(posedge clk); #1; end
      chk("midrst_owned_before", bus_a.owned, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_r_owned", {bus_a.r, bus_a.owned}, 0);
      chk("midrst_gcnt", bus_a.grant_cnt, 0);
      @(negedge clk); rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", done_a, 0);
      chk("midrst_gcnt_after", bus_a.grant_cnt, 0);

      // Contention: both accepted on the same edge
      fork
         acquire(0, 5);
         acquire(1, 5);
      join
      wait_idle("cont_idle");
      chk("cont_gcnt_a", bus_a.grant_cnt, 1);
      chk("cont_gcnt_b", bus_b.grant_cnt, 1);
      chk("cont_done",   {done_a[7:0], done_b[7:0]}, 16'h0101);

      fork
         rnd_client(0, 25);
         rnd_client(1, 25);
      join
      wait_idle("rnd_idle");
      chk("rnd_done_a",  done_a, acc_a);
      chk("rnd_done_b",  done_b, acc_b);
      chk("rnd_gcnt_a",  bus_a.grant_cnt, 16'(acc_a));
      chk("rnd_gcnt_b",  bus_b.grant_cnt, 16'(acc_b));
      chk("rnd_tmo",     tmo_a + tmo_b, 0);
      chk("rnd_pending", q_a.size() + q_b.size(), 0);
      chk("invariants",  viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mutex_req_ctrl.md
Name: mutex_req_ctrl

Overview:
- Synchronous client-side requester for the async two-way mutex arbiter element; drives one request line (r) and consumes the matching grant line (g).
- Converts a single-cycle acquire/length command from clocked logic into a correct four-phase r/g handshake.
- Holds the grant for a programmed number of cycles, with a grant-wait timeout.
- One instance sits on each mutex port; the grant input is asynchronous and is synchronised internally.

Parameters:
- SYNC_STAGES, 2, flops in the grant synchroniser (min 2).
- LEN_W, 8, width of the hold-length field.
- TO_W, 10, width of the grant-wait timeout counter.
- TIMEOUT, 1000, cycles to wait for grant before withdrawing the request; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- acq_valid  in  1  client requests access.
- acq_len  in  LEN_W  critical-section length in cycles; 0 is treated as 1.
- acq_ready  out  1  controller can accept a command.
- r  out  1  request to mutex; registered output.
- g  in  1  grant from mutex; asynchronous.
- owned  out  1  high while the grant is held; the client may use the shared resource.
- done  out  1  one-cycle pulse when a successful transaction completes.
- timeout  out  1  one-cycle pulse when the request is withdrawn without a grant.
- grant_cnt  out  16  count of successful grants; wraps.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; r=0, owned=0, done=0, timeout=0, grant_cnt=0.
  - Synchroniser flops, hold counter and timeout counter cleared.
  - Asserting reset mid-transaction drops r on that edge regardless of state. Any in-flight grant is discarded.
- Grant synchroniser: g_s = g delayed through SYNC_STAGES flops. Only g_s is used by the FSM.
- acq_ready = (state==IDLE) and g_s==0 and not rst. This prevents re-requesting before the previous grant has fallen (four-phase return-to-zero).
- State IDLE:
  - On acq_valid & acq_ready: latch len = max(acq_len,1), set r=1, clear the timeout counter, go to REQ.
  - r rises on the edge following acceptance.
- State REQ (r=1):
  - If g_s=1: go to HOLD, load the hold counter with len, set owned=1, increment grant_cnt.
  - Else, if TIMEOUT!=0 and the timeout counter reaches TIMEOUT-1: set r=0, go to REL with abort flag=1.
  - Otherwise increment the timeout counter.
  - If grant and timeout expiry coincide in the same cycle, the grant wins.
- State HOLD:
  - owned=1 for exactly len cycles; the counter decrements each cycle.
  - On the last cycle (counter==1): next edge owned=0, r=0, go to REL with abort flag=0.
  - r never falls while owned=1.
- State REL (r=0):
  - Wait for g_s==0. Mandatory also after a timeout, because a late grant may have been issued before r fell.
  - When g_s==0: return to IDLE.
  - On that same edge, pulse done (abort=0) or timeout (abort=1) for one cycle.
  - A grant that rises during REL is never reported as owned.
- owned is registered and equals (state==HOLD). done and timeout are mutually exclusive.
- grant_cnt wraps 0xFFFF -> 0x0000.
- acq_valid while acq_ready=0 is ignored. The client must hold acq_valid until it sees acq_ready.
- Minimum transaction, with g responding immediately, len=1 and SYNC_STAGES=2:
  - r rises at accept+1.
  - owned at accept+1+2+1.
  - done pulses SYNC_STAGES+1 cycles after r falls.

Test Plan:
- Basic transaction: rst then acq_valid=1, acq_len=3, model g = r delayed 2 cycles → owned high exactly 3 cycles; r falls the cycle owned falls; done pulses once; grant_cnt=1; acq_ready returns 1.
- acq_len=0: → owned high exactly 1 cycle; done pulses once.
- Contention with two instances on a behavioural mutex, both acquiring in the same cycle with len=5 → owned never high on both simultaneously; both eventually pulse done; grant_cnt=1 on each.
- Timeout: TIMEOUT=8, g held 0 → r falls 8 cycles after rising; timeout pulses once; no done; grant_cnt unchanged.
- Late grant: TIMEOUT=8, g rises 1 cycle after r falls, then drops 4 cycles later → owned stays 0; the timeout pulse waits until g_s==0; acq_ready stays 0 until then.
- Reset mid-HOLD: assert rst in the 2nd of 5 hold cycles → r=0 and owned=0 on that edge; grant_cnt=0; no done pulse.
